pc_ctrl_unit: RTL and testbench
===============================

// Module: pc_ctrl_unit
// PURPOSE
//  Parametrised control-flow unit for the WISC core. It owns the PC register and resolves
//  conditional branches, JAL, JR/return and HLT in a single cycle, with a return-address stack (RAS).
//  Sits between decode (op/cond/offset/rs_val/flags) and fetch (pc) / register file (link write).
//  Adds over the earlier per-instruction blocks: always-taken cond, RAS with predict/mispredict,
//  a registered flush pulse, stall hold, and a halt drain counter.
// PARAMETERS
//  DATA_W     16  PC / register width
//  OFF_W      9   signed branch/jump offset width
//  RAS_DEPTH  4   return-address stack entries (power of 2, >=2)
//  HALT_DRAIN 3   cycles from HLT accept to halted assertion (>=1)
//  RESET_PC   0   PC value after reset
// PORTS
//  clk         in   1           clock, all state updates on rising edge
//  rst_n       in   1           reset; synchronous, active-low
//  stall       in   1           hold all state; instr_valid is ignored while stall=1
//  instr_valid in   1           op/cond/offset/rs_val are valid this cycle
//  op          in   3           OP_SEQ=0, OP_BR=1, OP_JAL=2, OP_JR=3, OP_RET=4, OP_HLT=5 (6,7 = OP_SEQ)
//  cond        in   3           branch condition (OP_BR only)
//  offset      in   OFF_W       signed offset, sign-extended to DATA_W
//  rs_val      in   DATA_W      jump register value (OP_JR/OP_RET)
//  flag_n/v/z  in   1 each      ALU flags N, V, Z
//  pc          out  DATA_W      current PC to fetch
//  taken       out  1           comb: the accepted instr redirects the PC this cycle
//  flush       out  1           registered: 1-cycle pulse the cycle after taken
//  link_we     out  1           comb: write R15 (OP_JAL accepted)
//  link_data   out  DATA_W      comb: pc+1
//  ras_pred    out  DATA_W      RAS top-of-stack (0 when empty)
//  ras_valid   out  1           RAS non-empty
//  ras_mispred out  1           comb: OP_RET accepted with ras_valid=1 and ras_pred!=rs_val
//  ras_ovf     out  1           sticky: a push overwrote the oldest entry; cleared only by reset
//  halted      out  1           core halted; register dump may proceed
// BEHAVIOUR
//  Accept = instr_valid & ~stall & state==RUN. Non-accepted cycles: PC holds, no RAS/link side effects.
//  Reset (rst_n=0 at edge): pc=RESET_PC, state=RUN, drain cnt=0, flush=0, RAS empty, ras_ovf=0,
//   halted=0; comb outputs are therefore 0 (ras_pred=0). Reset mid-drain or in HALTED returns to RUN.
//  Sequential next PC = pc+1. Target = pc+1+sext(offset). All adds modulo 2^DATA_W (wrap, no flag).
//  Cond: 000 NE ~Z; 001 EQ Z; 010 GT ~Z&~N; 011 LT N; 100 GE Z|~N; 101 LE N|Z; 110 OV V; 111 always.
//  OP_BR: taken=cond true; pc<=taken?target:pc+1.  OP_SEQ: pc<=pc+1, taken=0.
//  OP_JAL: taken=1, pc<=target, link_we=1, link_data=pc+1, push pc+1 onto RAS.
//  OP_JR: taken=1, pc<=rs_val, RAS untouched.  OP_RET: taken=1, pc<=rs_val (rs_val is authoritative),
//   pop RAS if non-empty; pop on empty is a no-op with ras_mispred=0.
//  RAS: circular array plus count (0..RAS_DEPTH). A push when full overwrites the oldest entry,
//   count stays RAS_DEPTH, and ras_ovf<=1. Push and pop never occur in the same cycle.
//  flush <= taken & accept (1-cycle latency). While stall=1, flush holds its value.
//  FSM: RUN --HLT accepted--> DRAIN (cnt=HALT_DRAIN-1, pc holds, taken=0)
//   DRAIN: if cnt==0 -> HALTED else cnt-=1 (stall freezes cnt). HALTED: halted=1; only reset exits.
//   The PC does not advance in DRAIN or HALTED; instructions in those states are ignored.
// STRUCTURE
//  Shared package ctrl_pkg: op encodings OP_*, cond encodings COND_*, FSM state typedef
//   {RUN, DRAIN, HALTED}, localparam RAS_PTR_W=$clog2(RAS_DEPTH).
//  One sub-module: ras_stack #(DATA_W,RAS_DEPTH) (push/pop/top/valid/ovf, sync active-low reset).
//  Condition decode and next-PC mux stay inline in pc_ctrl_unit.
// TESTING
//  Reset: rst_n=0 for 2 cycles -> pc=0, halted=0, flush=0, ras_valid=0, ras_ovf=0.
//  BR at pc=0x0010, off=-3, cond=EQ, Z=1 -> taken=1, pc=0x000E next, flush=1 one cycle; Z=0 -> pc=0x0011.
//  Cond sweep: all 8 conds x all N/V/Z combos against the table; cond=111 is always taken.
//  JAL at 0x0020, off=+0x10 -> link_we=1, link_data=0x0021, pc=0x0031, ras_pred=0x0021;
//   RET rs_val=0x0021 -> ras_mispred=0, pc=0x0021; RET rs_val=0x0022 after a new JAL -> ras_mispred=1.
//  Five JALs with RAS_DEPTH=4 -> ras_ovf=1, four RETs pop 5th..2nd link, 5th RET on empty: no-op pop.
//  HLT with HALT_DRAIN=3 plus 1 stall cycle mid-drain -> halted rises 4 cycles after accept;
//   rst_n=0 during DRAIN -> RUN, pc=RESET_PC. pc=0xFFFF OP_SEQ -> pc wraps to 0x0000.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the WISC control-flow unit: opcodes, branch conditions, FSM states,
// and the condition-evaluation helper used by the PC controller.
package ctrl_pkg;

  localparam logic [2:0] OP_SEQ = 3'd0;
  localparam logic [2:0] OP_BR  = 3'd1;
  localparam logic [2:0] OP_JAL = 3'd2;
  localparam logic [2:0] OP_JR  = 3'd3;
  localparam logic [2:0] OP_RET = 3'd4;
  localparam logic [2:0] OP_HLT = 3'd5;

  localparam logic [2:0] COND_NE = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_GT = 3'd2;
  localparam logic [2:0] COND_LT = 3'd3;
  localparam logic [2:0] COND_GE = 3'd4;
  localparam logic [2:0] COND_LE = 3'd5;
  localparam logic [2:0] COND_OV = 3'd6;
  localparam logic [2:0] COND_AL = 3'd7;

  localparam int RAS_DEPTH_DEF = 4;
  localparam int RAS_PTR_W     = $clog2(RAS_DEPTH_DEF);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} ctrl_state_e;

  function automatic logic cond_eval(input logic [2:0] cond, input logic n, input logic v,
                                     input logic z);
    logic res;
    case (cond)
      COND_NE: res = ~z;
      COND_EQ: res = z;
      COND_GT: res = ~z & ~n;
      COND_LT: res = n;
      COND_GE: res = z | ~n;
      COND_LE: res = n | z;
      COND_OV: res = v;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry and sets a
// sticky overflow flag; a pop on empty does nothing.
module ras_stack
  import ctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic              valid,
  output logic              ovf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [DATA_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != FULL) cnt_d = cnt_q + CNT_W'(1);
      else               ovf_d = 1'b1;
    end else if (pop && cnt_q != '0) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage carries no reset; an empty count masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

  assign top_idx = ptr_q - PTR_W'(1);
  assign valid   = (cnt_q != '0);
  assign top     = valid ? mem_q[top_idx] : '0;
  assign ovf     = ovf_q;

endmodule

// File: rtl/pc_ctrl_unit.sv
// WISC control-flow unit: owns the PC, resolves branches/JAL/JR/RET/HLT in one cycle,
// tracks return addresses, and drains to a halted state after HLT.
module pc_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                OFF_W      = 9,
  parameter int                RAS_DEPTH  = 4,
  parameter int                HALT_DRAIN = 3,
  parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic [2:0]        op,
  input  logic [2:0]        cond,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] rs_val,
  input  logic              flag_n,
  input  logic              flag_v,
  input  logic              flag_z,
  output logic [DATA_W-1:0] pc,
  output logic              taken,
  output logic              flush,
  output logic              link_we,
  output logic [DATA_W-1:0] link_data,
  output logic [DATA_W-1:0] ras_pred,
  output logic              ras_valid,
  output logic              ras_mispred,
  output logic              ras_ovf,
  output logic              halted
);

  localparam int CNT_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;

  ctrl_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        pc_q, pc_d;
  logic                     flush_q, flush_d;
  logic                     accept, ras_push, ras_pop;
  logic [2:0]               op_eff;
  logic signed [DATA_W-1:0] off_sext;
  logic [DATA_W-1:0]        pc_inc, target;

  assign off_sext = {{(DATA_W - OFF_W){offset[OFF_W-1]}}, offset};
  assign pc_inc   = pc_q + DATA_W'(1);
  assign target   = pc_inc + $unsigned(off_sext);
  assign op_eff   = (op > OP_HLT) ? OP_SEQ : op;
  assign accept   = instr_valid & ~stall & (state_q == RUN);

  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    taken    = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (accept) begin
      case (op_eff)
        OP_BR: begin
          taken = cond_eval(cond, flag_n, flag_v, flag_z);
          pc_d  = taken ? target : pc_inc;
        end
        OP_JAL: begin
          taken    = 1'b1;
          pc_d     = target;
          ras_push = 1'b1;
        end
        OP_JR: begin
          taken = 1'b1;
          pc_d  = rs_val;
        end
        OP_RET: begin
          taken   = 1'b1;
          pc_d    = rs_val;
          ras_pop = 1'b1;
        end
        OP_HLT: begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(HALT_DRAIN - 1);
        end
        default: pc_d = pc_inc;
      endcase
    end else if (state_q == DRAIN && !stall) begin
      if (cnt_q == '0) state_d = HALTED;
      else             cnt_d   = cnt_q - CNT_W'(1);
    end
    flush_d = stall ? flush_q : taken;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  ras_stack #(
    .DATA_W   (DATA_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_inc),
    .top      (ras_pred),
    .valid    (ras_valid),
    .ovf      (ras_ovf)
  );

  assign pc          = pc_q;
  assign flush       = flush_q;
  assign link_we     = ras_push;
  assign link_data   = link_we ? pc_inc : '0;
  assign ras_mispred = ras_pop & ras_valid & (ras_pred != rs_val);
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Scoreboard bench for pc_ctrl_unit: the driver pushes per-cycle expectations from an
// architectural model, an independent monitor pops and compares them at the falling edge.
module tb_pc_ctrl_unit;

  localparam int DATA_W     = 16;
  localparam int OFF_W      = 9;
  localparam int RAS_DEPTH  = 4;
  localparam int HALT_DRAIN = 3;

  logic              clk, rst_n, stall, instr_valid, flag_n, flag_v, flag_z;
  logic [2:0]        op, cond;
  logic [OFF_W-1:0]  offset;
  logic [DATA_W-1:0] rs_val, pc, link_data, ras_pred;
  logic              taken, flush, link_we, ras_valid, ras_mispred, ras_ovf, halted;

  pc_ctrl_unit #(
    .DATA_W(DATA_W), .OFF_W(OFF_W), .RAS_DEPTH(RAS_DEPTH), .HALT_DRAIN(HALT_DRAIN),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr_valid(instr_valid), .op(op),
    .cond(cond), .offset(offset), .rs_val(rs_val), .flag_n(flag_n), .flag_v(flag_v),
    .flag_z(flag_z), .pc(pc), .taken(taken), .flush(flush), .link_we(link_we),
    .link_data(link_data), .ras_pred(ras_pred), .ras_valid(ras_valid),
    .ras_mispred(ras_mispred), .ras_ovf(ras_ovf), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pc; bit taken; bit flush; bit link_we; int link_data;
    int ras_pred; bit ras_valid; bit ras_mispred; bit ras_ovf; bit halted;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Architectural model state
  int m_pc;
  bit m_flush, m_ovf, m_halted, m_draining;
  int m_left;
  int m_ras[$];

  function automatic bit cond_ok(int c, bit n, bit v, bit z);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_flush = 0; m_ovf = 0; m_halted = 0; m_draining = 0; m_left = 0;
    m_ras.delete();
  endtask

  task automatic step(input bit r, input bit s, input bit v, input int o, input int c,
                      input int off, input int rs, input bit n, input bit vf, input bit z);
    exp_t e;
    bit   acc, tk;
    int   opn, tgt, rsm, nxt;
    @(posedge clk); #1;
    rst_n = r; stall = s; instr_valid = v; op = 3'(o); cond = 3'(c);
    offset = OFF_W'(off); rs_val = 16'(rs); flag_n = n; flag_v = vf; flag_z = z;

    acc = v && !s && !m_draining && !m_halted;
    opn = (o > 5) ? 0 : o;
    rsm = rs & 'hFFFF;
    tgt = (m_pc + 1 + off) & 'hFFFF;
    tk  = acc && ((opn == 1) ? cond_ok(c, n, vf, z) : (opn == 2 || opn == 3 || opn == 4));
    e.pc          = m_pc;
    e.taken       = tk;
    e.flush       = m_flush;
    e.link_we     = acc && opn == 2;
    e.link_data   = e.link_we ? ((m_pc + 1) & 'hFFFF) : 0;
    e.ras_valid   = m_ras.size() > 0;
    e.ras_pred    = e.ras_valid ? m_ras[$] : 0;
    e.ras_mispred = acc && opn == 4 && e.ras_valid && m_ras[$] != rsm;
    e.ras_ovf     = m_ovf;
    e.halted      = m_halted;
    sb.push_back(e);

    if (!r) begin
      model_reset();
    end else if (!s) begin
      m_flush = tk;
      if (acc) begin
        nxt = (m_pc + 1) & 'hFFFF;
        case (opn)
          1: nxt = tk ? tgt : nxt;
          2: begin
            nxt = tgt;
            m_ras.push_back((m_pc + 1) & 'hFFFF);
            if (m_ras.size() > RAS_DEPTH) begin
              void'(m_ras.pop_front());
              m_ovf = 1;
            end
          end
          3: nxt = rsm;
          4: begin
            nxt = rsm;
            if (m_ras.size() > 0) void'(m_ras.pop_back());
          end
          5: begin
            nxt = m_pc;
            m_draining = 1;
            m_left = HALT_DRAIN;
          end
          default: ;
        endcase
        m_pc = nxt;
      end else if (m_draining) begin
        m_left--;
        if (m_left == 0) begin
          m_draining = 0;
          m_halted = 1;
        end
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic instr(input int o, input int c, input int off, input int rs,
                       input bit n, input bit vf, input bit z);
    step(1, 0, 1, o, c, off, rs, n, vf, z);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: every cycle is an output event; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", 32'(pc), 32'(e.pc));
        chk("taken", 32'(taken), 32'(e.taken));
        chk("flush", 32'(flush), 32'(e.flush));
        chk("link_we", 32'(link_we), 32'(e.link_we));
        chk("link_data", 32'(link_data), 32'(e.link_data));
        chk("ras_pred", 32'(ras_pred), 32'(e.ras_pred));
        chk("ras_valid", 32'(ras_valid), 32'(e.ras_valid));
        chk("ras_mispred", 32'(ras_mispred), 32'(e.ras_mispred));
        chk("ras_ovf", 32'(ras_ovf), 32'(e.ras_ovf));
        chk("halted", 32'(halted), 32'(e.halted));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int sel, o, rs;
    rst_n = 0; stall = 0; instr_valid = 0; op = 0; cond = 0; offset = 0; rs_val = 0;
    flag_n = 0; flag_v = 0; flag_z = 0;
    repeat (2) @(posedge clk);
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Branch EQ at 0x0010, offset -3: taken then not taken
    instr(3, 0, 0, 'h0010, 0, 0, 0);
    instr(1, 1, -3, 0, 0, 0, 1);
    idle(1);
    instr(3, 0, 0, 'h0010, 0, 0, 0);
    instr(1, 1, -3, 0, 0, 0, 0);
    idle(1);

    // Condition sweep over every N/V/Z combination
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++)
        instr(1, c, 2, 0, f[2], f[1], f[0]);

    // JAL / RET prediction and mispredict
    instr(3, 0, 0, 'h0020, 0, 0, 0);
    instr(2, 0, 'h10, 0, 0, 0, 0);
    instr(4, 0, 0, 'h0021, 0, 0, 0);
    instr(3, 0, 0, 'h0040, 0, 0, 0);
    instr(2, 0, 'h10, 0, 0, 0, 0);
    instr(4, 0, 0, 'h0022, 0, 0, 0);

    // Overflow: five calls, then five returns (last on empty)
    for (int i = 0; i < 5; i++) instr(2, 0, 'h20 + i, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) instr(4, 0, 0, 'h0100 + i * 3, 0, 0, 0);

    // Stall ignores instructions and holds the flush pulse
    instr(3, 0, 0, 'h0200, 0, 0, 0);
    step(1, 1, 1, 2, 0, 5, 0, 0, 0, 0);
    step(1, 1, 1, 3, 0, 0, 'h1234, 0, 0, 0);
    idle(1);

    // PC wrap and unused opcodes
    instr(3, 0, 0, 'hFFFF, 0, 0, 0);
    instr(0, 0, 0, 0, 0, 0, 0);
    instr(6, 7, 4, 0, 0, 0, 0);
    instr(7, 7, 4, 0, 0, 0, 0);

    // Random run
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      o = (sel < 2) ? ((sel == 0) ? 0 : $urandom_range(6, 7)) : (sel < 5) ? 1 :
          (sel < 7) ? 2 : (sel == 7) ? 3 : 4;
      rs = $urandom_range(0, 'hFFFF);
      if (o == 4 && m_ras.size() > 0 && $urandom_range(0, 1) == 1) rs = m_ras[$];
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) != 0),
           o, $urandom_range(0, 7), int'($urandom_range(0, 511)) - 256, rs,
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Halt with a mid-drain stall, instructions ignored while draining/halted
    instr(3, 0, 0, 'h0300, 0, 0, 0);
    instr(5, 0, 0, 0, 0, 0, 0);
    instr(2, 0, 3, 0, 0, 0, 0);
    step(1, 1, 1, 3, 0, 0, 'h55, 0, 0, 0);
    instr(0, 0, 0, 0, 0, 0, 0);
    idle(1);
    instr(3, 0, 0, 'h77, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Reset during drain returns to RUN at the reset PC
    instr(3, 0, 0, 'h0400, 0, 0, 0);
    instr(5, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 3, 0, 0, 'h99, 0, 0, 0);
    instr(0, 0, 0, 0, 0, 0, 0);
    instr(2, 0, 8, 0, 0, 0, 0);
    idle(2);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
